mips8_mc_controller: RTL and testbench
======================================

Name: mips8_mc_controller

Overview:
- Multicycle control FSM for the 8-bit MIPS-subset datapath.
- Consumes the opcode and funct fields of the instruction register, the ALU zero flag and a memory ready strobe.
- Produces every datapath select, enable and write strobe, plus the memory read/write strobes.
- Instructions are 32 bits, fetched one byte per FETCH state over the 8-bit memory port.

Parameters:
- none (opcode, funct and state encodings are fixed below)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- op  input  6  instr[31:26]
- funct  input  6  instr[5:0]
- zero  input  1  ALU result == 0, from the datapath
- memready  input  1  memory access completes this cycle; tie high for single-cycle memory
- memread  output  1  memory read strobe
- memwrite  output  1  memory write strobe
- alusrca  output  1  0=register A, 1=PC
- alusrcb  output  2  00=register B, 01=constant 1, 10=instr[7:0], 11=constx4
- iord  output  1  0=ALUOut address, 1=PC address
- memtoreg  output  1  0=memory data register, 1=ALUOut
- regdst  output  1  0=instr[13:11] (rd), 1=instr[18:16] (rt)
- regwrite  output  1  register file write enable
- pcsource  output  2  00=ALU result, 01=ALUOut, 10=constx4 (jump), 11=zero
- pcen  output  1  PC register enable
- irwrite  output  4  bit0 loads instr[31:24] … bit3 loads instr[7:0]
- alucontrol  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- illegal  output  1  one-cycle pulse on an undecodable instruction
- state  output  4  current state, for debug and verification

Behaviour:
- Single always block for the state register; async clear to FETCH1 when reset=0. Outputs are decoded from state (Moore), except pcen and the memready gating.
- While reset=0: all outputs 0, alucontrol=010, state=0.
- State encoding: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14. Code 15 goes to FETCH1 next cycle.
- Default in every state: all strobes 0, selects 0, alucontrol=010.
- Opcodes: LB=100000, SB=101000, RTYPE=000000, BEQ=000100, J=000010, ADDI=001000.
- Funct to alucontrol: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
- FETCHn (n=1..4):
  - memread=1, iord=1, alusrca=1, alusrcb=01, pcsource=00.
  - irwrite[n-1]=memready, pcen=memready.
  - Stays in FETCHn while memready=0; advances when memready=1.
  - PC increments exactly once per fetched byte.
- DECODE: alusrca=1, alusrcb=11 (branch target into ALUOut). Next state by op:
  - LB or SB → MEMADR
  - RTYPE with a legal funct → RTYPEEX
  - BEQ → BEQEX
  - J → JEX
  - ADDI → ADDIEX
  - any other op, or RTYPE with an unlisted funct → FETCH1, with illegal=1 for this cycle.
- MEMADR: alusrca=0, alusrcb=10. Next: LBRD if op=LB, else SBWR.
- LBRD: memread=1, iord=0. Holds until memready=1, then → LBWR.
- LBWR: regwrite=1, regdst=1, memtoreg=0 → FETCH1.
- SBWR: memwrite=1, iord=0. Holds until memready=1, then → FETCH1.
- RTYPEEX: alusrca=0, alusrcb=00, alucontrol from funct → RTYPEWR.
- RTYPEWR: regwrite=1, regdst=0, memtoreg=1, alucontrol from funct → FETCH1.
- BEQEX: alusrca=0, alusrcb=00, alucontrol=110, pcsource=01, pcen=zero → FETCH1.
- JEX: pcsource=10, pcen=1 → FETCH1.
- ADDIEX: alusrca=0, alusrcb=10 → ADDIWR.
- ADDIWR: regwrite=1, regdst=1, memtoreg=1 → FETCH1.
- Cycle counts with memready tied 1: LB=8, SB=7, R-type=7, ADDI=7, BEQ=6, J=6.
- Reset asserted mid-instruction: immediate return to FETCH1 with all strobes 0. No partial register or memory write after the reset edge.
- op and funct are sampled only in DECODE and later states; they must be stable from DECODE until the instruction completes.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release. Required: state=0, all outputs 0 during reset; first cycle after release memread=1, irwrite=0001, pcen=1.
- ADD, op=000000, funct=100000, memready=1. Required: states 0,1,2,3,4,9,10,0; alucontrol=010 in states 9 and 10; regwrite=1 only in state 10 with regdst=0, memtoreg=1.
- BEQ, op=000100: with zero=1, pcen=1 and pcsource=01 in state 11; repeat with zero=0, pcen=0. Both cases return to state 0.
- LB, op=100000, memready=0 for 2 cycles in FETCH2 and 3 cycles in LBRD. Required: irwrite=0010 and pcen=1 only on the FETCH2 cycle with memready=1; total 13 cycles; regwrite=1 with regdst=1 in LBWR.
- Illegal op=111111: DECODE → FETCH1 with illegal=1 for exactly one cycle. Repeat with RTYPE funct=000111: same response.
- Reset mid-SBWR while memwrite=1: memwrite drops to 0 asynchronously; state=0; fetch restarts after release.

Source files
------------

// File: rtl/mips8_mc_controller_if.sv
// Control bus between the mips8 multicycle controller and its datapath.
// Inputs to the controller: op, funct (instruction fields), zero (ALU flag),
// memready (memory access completes this cycle).
// Outputs from the controller: memory strobes, datapath selects and enables,
// illegal-instruction pulse and the current state for debug.
// master = controller side, slave = datapath/memory side.
interface mips8_mc_controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memready;
   logic       memread;
   logic       memwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic       regwrite;
   logic [1:0] pcsource;
   logic       pcen;
   logic [3:0] irwrite;
   logic [2:0] alucontrol;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  op, funct, zero, memready,
      output memread, memwrite, alusrca, alusrcb, iord, memtoreg, regdst,
             regwrite, pcsource, pcen, irwrite, alucontrol, illegal, state
   );

   modport slave (
      output op, funct, zero, memready,
      input  memread, memwrite, alusrca, alusrcb, iord, memtoreg, regdst,
             regwrite, pcsource, pcen, irwrite, alucontrol, illegal, state
   );
endinterface

// File: rtl/mips8_mc_controller.sv
// Multicycle control FSM for the 8-bit MIPS-subset datapath.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - controller side of mips8_mc_controller_if (instruction fields,
//           zero flag, memready in; all datapath/memory controls out)
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH1-4 | read instruction byte n, PC += 1 per byte
// DECODE   | branch target into ALUOut, dispatch on op
// MEMADR   | compute A + imm for LB/SB
// LBRD     | read data memory, wait for memready
// LBWR     | write loaded byte into rt
// SBWR     | write B to data memory, wait for memready
// RTYPEEX  | A op B
// RTYPEWR  | write ALUOut into rd
// BEQEX    | A - B, take branch when zero
// JEX      | load jump target into PC
// ADDIEX   | A + imm
// ADDIWR   | write ALUOut into rt
module mips8_mc_controller (
   input  logic                      clk,
   input  logic                      reset,
   mips8_mc_controller_if.master     bus
);

   typedef enum logic [3:0] {
      FETCH1  = 4'd0,
      FETCH2  = 4'd1,
      FETCH3  = 4'd2,
      FETCH4  = 4'd3,
      DECODE  = 4'd4,
      MEMADR  = 4'd5,
      LBRD    = 4'd6,
      LBWR    = 4'd7,
      SBWR    = 4'd8,
      RTYPEEX = 4'd9,
      RTYPEWR = 4'd10,
      BEQEX   = 4'd11,
      JEX     = 4'd12,
      ADDIEX  = 4'd13,
      ADDIWR  = 4'd14,
      UNUSED  = 4'd15
   } state_e;

   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;

   state_e state_q, state_d;

   // Decoded ALU operation for R-type; valid_o flags a listed funct.
   function automatic logic [3:0] funct_dec(input logic [5:0] f);
      case (f)
         6'b100000: funct_dec = {1'b1, 3'b010};
         6'b100010: funct_dec = {1'b1, 3'b110};
         6'b100100: funct_dec = {1'b1, 3'b000};
         6'b100101: funct_dec = {1'b1, 3'b001};
         6'b101010: funct_dec = {1'b1, 3'b111};
         default:   funct_dec = {1'b0, 3'b010};
      endcase
   endfunction

   logic [3:0] fdec;
   assign fdec = funct_dec(bus.funct);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= FETCH1;
      else        state_q <= state_d;
   end

   assign bus.state = state_q;

   always_comb begin
      state_d        = state_q;
      bus.memread    = 1'b0;
      bus.memwrite   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = 2'b00;
      bus.iord       = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.regdst     = 1'b0;
      bus.regwrite   = 1'b0;
      bus.pcsource   = 2'b00;
      bus.pcen       = 1'b0;
      bus.irwrite    = 4'b0000;
      bus.alucontrol = ALU_ADD;
      bus.illegal    = 1'b0;
      // Gating on reset keeps every strobe low the instant reset asserts,
      // not only after the next clock edge.
      if (reset) begin
         case (state_q)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
               bus.memread = 1'b1;
               bus.iord    = 1'b1;
               bus.alusrca = 1'b1;
               bus.alusrcb = 2'b01;
               bus.irwrite = 4'(bus.memready) << state_q[1:0];
               bus.pcen    = bus.memready;
               // FETCH4 + 1 lands on DECODE.
               if (bus.memready) state_d = state_e'(state_q + 4'd1);
            end
            DECODE: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = 2'b11;
               case (bus.op)
                  OP_LB, OP_SB: state_d = MEMADR;
                  OP_BEQ:       state_d = BEQEX;
                  OP_J:         state_d = JEX;
                  OP_ADDI:      state_d = ADDIEX;
                  OP_RTYPE: begin
                     if (fdec[3]) begin
                        state_d = RTYPEEX;
                     end else begin
                        state_d     = FETCH1;
                        bus.illegal = 1'b1;
                     end
                  end
                  default: begin
                     state_d     = FETCH1;
                     bus.illegal = 1'b1;
                  end
               endcase
            end
            MEMADR: begin
               bus.alusrcb = 2'b10;
               state_d     = (bus.op == OP_LB) ? LBRD : SBWR;
            end
            LBRD: begin
               bus.memread = 1'b1;
               if (bus.memready) state_d = LBWR;
            end
            LBWR: begin
               bus.regwrite = 1'b1;
               bus.regdst   = 1'b1;
               state_d      = FETCH1;
            end
            SBWR: begin
               bus.memwrite = 1'b1;
               if (bus.memready) state_d = FETCH1;
            end
            RTYPEEX: begin
               bus.alucontrol = fdec[2:0];
               state_d        = RTYPEWR;
            end
            RTYPEWR: begin
               bus.regwrite   = 1'b1;
               bus.memtoreg   = 1'b1;
               bus.alucontrol = fdec[2:0];
               state_d        = FETCH1;
            end
            BEQEX: begin
               bus.alucontrol = ALU_SUB;
               bus.pcsource   = 2'b01;
               bus.pcen       = bus.zero;
               state_d        = FETCH1;
            end
            JEX: begin
               bus.pcsource = 2'b10;
               bus.pcen     = 1'b1;
               state_d      = FETCH1;
            end
            ADDIEX: begin
               bus.alusrcb = 2'b10;
               state_d     = ADDIWR;
            end
            ADDIWR: begin
               bus.regwrite = 1'b1;
               bus.regdst   = 1'b1;
               bus.memtoreg = 1'b1;
               state_d      = FETCH1;
            end
            default: state_d = FETCH1;
         endcase
      end
   end

endmodule

// File: tb/tb_mips8_mc_controller.sv
module tb_mips8_mc_controller;

   logic clk;
   logic reset;

   mips8_mc_controller_if bus();

   mips8_mc_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      int   st;
      logic mr;
   } step_t;

   step_t       tq[$];
   logic [23:0] seen [16];
   int          ill_cnt;
   logic [5:0]  cur_op;
   logic [5:0]  cur_fn;
   logic        cur_z;

   localparam logic [23:0] RST_VEC = 24'h000040;

   // Observed vector layout:
   // [23]memread [22]memwrite [21]alusrca [20:19]alusrcb [18]iord
   // [17]memtoreg [16]regdst [15]regwrite [14:13]pcsource [12]pcen
   // [11:8]irwrite [7:5]alucontrol [4]illegal [3:0]state
   function automatic logic [23:0] obs();
      return {bus.memread, bus.memwrite, bus.alusrca, bus.alusrcb, bus.iord,
              bus.memtoreg, bus.regdst, bus.regwrite, bus.pcsource, bus.pcen,
              bus.irwrite, bus.alucontrol, bus.illegal, bus.state};
   endfunction

   task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   // ALU operation table for R-type funct codes; -1 when unlisted.
   function automatic int fn_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 2;
         6'b100010: return 6;
         6'b100100: return 0;
         6'b100101: return 1;
         6'b101010: return 7;
         default:   return -1;
      endcase
   endfunction

   // Required controls for one cycle, given the step of the instruction
   // the controller is in and the inputs seen during that cycle.
   function automatic logic [23:0] model_out(input int st, input logic [5:0] op,
                                             input logic [5:0] fn, input logic z,
                                             input logic mr);
      logic       mrd  = 1'b0, mwr = 1'b0, asa = 1'b0, iord = 1'b0;
      logic       m2r  = 1'b0, rdst = 1'b0, rw = 1'b0, pce = 1'b0, ill = 1'b0;
      logic [1:0] asb  = 2'b00, pcs = 2'b00;
      logic [3:0] irw  = 4'b0000;
      logic [2:0] alu  = 3'b010;
      if (st <= 3) begin
         mrd = 1'b1; iord = 1'b1; asa = 1'b1; asb = 2'b01;
         irw = mr ? (4'b0001 << st) : 4'b0000;
         pce = mr;
      end else if (st == 4) begin
         asa = 1'b1; asb = 2'b11;
         ill = !(op inside {6'b100000, 6'b101000, 6'b000100, 6'b000010, 6'b001000} ||
                 (op == 6'b000000 && fn_alu(fn) >= 0));
      end else if (st == 5) asb = 2'b10;
      else if (st == 6) mrd = 1'b1;
      else if (st == 7) begin rw = 1'b1; rdst = 1'b1; end
      else if (st == 8) mwr = 1'b1;
      else if (st == 9) alu = 3'(fn_alu(fn));
      else if (st == 10) begin rw = 1'b1; m2r = 1'b1; alu = 3'(fn_alu(fn)); end
      else if (st == 11) begin alu = 3'b110; pcs = 2'b01; pce = z; end
      else if (st == 12) begin pcs = 2'b10; pce = 1'b1; end
      else if (st == 13) asb = 2'b10;
      else if (st == 14) begin rw = 1'b1; rdst = 1'b1; m2r = 1'b1; end
      return {mrd, mwr, asa, asb, iord, m2r, rdst, rw, pcs, pce, irw, alu, ill, 4'(st)};
   endfunction

   task automatic push(input int st, input logic mr);
      step_t s;
      s.st = st;
      s.mr = mr;
      tq.push_back(s);
   endtask

   // Expected step sequence of one instruction: four fetched bytes (with
   // optional stall cycles on one byte), decode, then the class tail.
   task automatic build(input logic [5:0] op, input logic [5:0] fn,
                        input int stall_byte, input int stall_n, input int mstall);
      tq.delete();
      for (int b = 0; b < 4; b++) begin
         if (b == stall_byte) repeat (stall_n) push(b, 1'b0);
         push(b, 1'b1);
      end
      push(4, 1'b1);
      case (op)
         6'b100000: begin
            push(5, 1'b1);
            repeat (mstall) push(6, 1'b0);
            push(6, 1'b1);
            push(7, 1'b1);
         end
         6'b101000: begin
            push(5, 1'b1);
            repeat (mstall) push(8, 1'b0);
            push(8, 1'b1);
         end
         6'b000000: if (fn_alu(fn) >= 0) begin push(9, 1'b1); push(10, 1'b1); end
         6'b000100: push(11, 1'b1);
         6'b000010: push(12, 1'b1);
         6'b001000: begin push(13, 1'b1); push(14, 1'b1); end
         default: ;
      endcase
   endtask

   // Entered at a falling edge; leaves at the falling edge after the last step.
   task automatic exec(input string nm, input int limit);
      int n;
      logic [23:0] g;
      n = (limit < 0) ? tq.size() : limit;
      for (int i = 0; i < n; i++) begin
         bus.memready = tq[i].mr;
         #1;
         g = obs();
         chk($sformatf("%s step%0d", nm, i), g,
             model_out(tq[i].st, cur_op, cur_fn, cur_z, tq[i].mr));
         seen[tq[i].st] = g;
         if (g[4]) ill_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic setup(input logic [5:0] op, input logic [5:0] fn, input logic z);
      cur_op = op; cur_fn = fn; cur_z = z;
      bus.op = op; bus.funct = fn; bus.zero = z;
      for (int k = 0; k < 16; k++) seen[k] = '0;
      ill_cnt = 0;
   endtask

   task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input int stall_byte, input int stall_n,
                      input int mstall, input int exp_len);
      setup(op, fn, z);
      build(op, fn, stall_byte, stall_n, mstall);
      chk({nm, " cycles"}, 24'(tq.size()), 24'(exp_len));
      exec(nm, -1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] v;
      reset        = 1'b0;
      bus.memready = 1'b0;
      setup(6'b0, 6'b0, 1'b0);

      repeat (3) begin
         @(negedge clk); #1;
         chk("reset outputs", obs(), RST_VEC);
      end
      @(negedge clk);
      reset        = 1'b1;
      bus.memready = 1'b1;
      #1;
      v = obs();
      chk("first fetch memread", 24'(v[23]), 24'd1);
      chk("first fetch irwrite", 24'(v[11:8]), 24'h1);
      chk("first fetch pcen", 24'(v[12]), 24'd1);

      run("add", 6'b000000, 6'b100000, 1'b0, -1, 0, 0, 7);
      chk("add ex alu", 24'(seen[9][7:5]), 24'd2);
      chk("add wr rw/rdst/m2r", 24'({seen[10][15], seen[10][16], seen[10][17]}), 24'b101);
      chk("add illegal count", 24'(ill_cnt), 24'd0);

      run("sub", 6'b000000, 6'b100010, 1'b1, -1, 0, 0, 7);
      chk("sub ex alu", 24'(seen[9][7:5]), 24'd6);
      run("and", 6'b000000, 6'b100100, 1'b0, -1, 0, 0, 7);
      run("or",  6'b000000, 6'b100101, 1'b0, -1, 0, 0, 7);
      run("slt", 6'b000000, 6'b101010, 1'b0, -1, 0, 0, 7);
      chk("slt wr alu", 24'(seen[10][7:5]), 24'd7);

      run("beq_t", 6'b000100, 6'b000000, 1'b1, -1, 0, 0, 6);
      chk("beq taken pcen/pcsrc", 24'({seen[11][12], seen[11][14:13]}), 24'b101);
      run("beq_nt", 6'b000100, 6'b000000, 1'b0, -1, 0, 0, 6);
      chk("beq not taken pcen", 24'(seen[11][12]), 24'd0);

      run("lb", 6'b100000, 6'b000000, 1'b0, 1, 2, 3, 13);
      chk("lb wr rw/rdst", 24'({seen[7][15], seen[7][16]}), 24'b11);
      chk("lb fetch2 irwrite", 24'(seen[1][11:8]), 24'h2);

      run("sb", 6'b101000, 6'b000000, 1'b0, -1, 0, 0, 7);
      run("addi", 6'b001000, 6'b000000, 1'b0, -1, 0, 0, 7);
      chk("addi wr rw/rdst/m2r", 24'({seen[14][15], seen[14][16], seen[14][17]}), 24'b111);
      run("j", 6'b000010, 6'b000000, 1'b0, 2, 1, 0, 7);
      chk("j pcsrc/pcen", 24'({seen[12][14:13], seen[12][12]}), 24'b101);

      run("ill_op", 6'b111111, 6'b100000, 1'b0, -1, 0, 0, 5);
      chk("ill_op pulse count", 24'(ill_cnt), 24'd1);
      run("ill_fn", 6'b000000, 6'b000111, 1'b0, -1, 0, 0, 5);
      chk("ill_fn pulse count", 24'(ill_cnt), 24'd1);

      // Reset while a store is waiting on memory.
      setup(6'b101000, 6'b000000, 1'b0);
      build(6'b101000, 6'b000000, -1, 0, 2);
      exec("sb_rst", 6);
      bus.memready = 1'b0;
      #1;
      v = obs();
      chk("sbwr memwrite before reset", 24'(v[22]), 24'd1);
      chk("sbwr state", 24'(v[3:0]), 24'd8);
      #1;
      reset = 1'b0;
      #1;
      chk("mid-store reset outputs", obs(), RST_VEC);
      @(negedge clk); #1;
      chk("held reset outputs", obs(), RST_VEC);
      @(negedge clk);
      reset = 1'b1;
      run("j_after_rst", 6'b000010, 6'b000000, 1'b0, -1, 0, 0, 6);
      #1;
      chk("final state", 24'(bus.state), 24'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
